// File: rtl/audio_pwm_out.sv
// audio_pwm_out: 8-bit sample holding register feeding a 256-tick PWM
// modulator with frame-start marking and a sticky overrun flag.
// Optional build macro AUDIO_PWM_SD_EN replaces the PWM compare with a
// first-order delta-sigma modulator; the frame/load logic is unchanged.
//
// sample_valid/sample_in form a push-only strobe: there is no ready, every
// strobe is captured, and a strobe that lands on an unconsumed sample sets
// overrun while still overwriting it.
module audio_pwm_out #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       enable,
    input  logic       clear_ovr,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [7:0] duty,
    output logic       overrun
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic [7:0]    hold;
    logic          pend;
    logic          tick;
    logic          wrap;

    logic [7:0]    duty_d;
    logic          pend_d;
    logic          overrun_d;

    assign tick = enable && (presc == PRESC_LAST);
    assign wrap = tick && (cnt == 8'hFF);

    // Prescaler: one tick every DIV enabled clocks, parked at 0 while disabled.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Period counter: 256 ticks per frame, restarts from 0 after re-enable.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Next duty / pending / overrun: a strobe on the wrap cycle bypasses the
    // holding register and is consumed immediately, so it never overruns.
    always_comb begin
        duty_d    = duty;
        pend_d    = pend;
        overrun_d = overrun;
        if (wrap) begin
            if (sample_valid) begin
                duty_d = sample_in;
            end else if (pend) begin
                duty_d = hold;
            end
            pend_d = 1'b0;
        end else if (sample_valid) begin
            pend_d = 1'b1;
        end
        if (sample_valid && pend && !wrap) begin
            overrun_d = 1'b1;
        end else if (clear_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Capture, load and status registers; capture runs regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty        <= 8'h80;
            hold        <= 8'h80;
            pend        <= 1'b0;
            overrun     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            duty        <= duty_d;
            pend        <= pend_d;
            overrun     <= overrun_d;
            frame_start <= wrap;
            if (sample_valid) begin
                hold <= sample_in;
            end
        end
    end

`ifdef AUDIO_PWM_SD_EN
    // Only the low byte of the 9-bit accumulator carries state; bit 8 of the
    // fresh sum is the output bit, so it is never stored.
    logic [7:0] acc;
    logic [8:0] acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, duty};

    // Delta-sigma modulator: one accumulate per tick, output held between ticks.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc     <= 8'd0;
            pwm_out <= 1'b0;
        end else if (tick) begin
            acc     <= acc_sum[7:0];
            pwm_out <= acc_sum[8];
        end
    end
`else
    // PWM compare: high while the period counter is below the duty value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (cnt < duty);
        end
    end
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// Testbench for audio_pwm_out: directed vectors, frame-window measurements
// and randomized traffic checked cycle by cycle against a timeline model.
// Honors AUDIO_PWM_SD_EN the same way as the design.
module tb_audio_pwm_out;

    localparam int DIV   = 2;
    localparam int FRAME = 256 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       enable;
    logic       clear_ovr;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] duty;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    audio_pwm_out #(.DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .enable       (enable),
        .clear_ovr    (clear_ovr),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .duty         (duty),
        .overrun      (overrun)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Time is tracked as the number of consecutive enabled clocks; tick, cnt
    // and frame boundaries are derived from it arithmetically.
    int         m_pos  = 0;
    logic [7:0] m_duty = 8'h80;
    logic [7:0] m_hold = 8'h80;
    bit         m_pend = 1'b0;
    bit         m_ovr  = 1'b0;
    bit         m_pwm  = 1'b0;
    bit         m_fs   = 1'b0;
    longint     m_sum  = 0;

    task automatic model_step();
        int cnt_now;
        bit tick;
        bit wrap;
        if (rst) begin
            m_pos = 0; m_duty = 8'h80; m_hold = 8'h80; m_pend = 0;
            m_ovr = 0; m_pwm = 0; m_fs = 0; m_sum = 0;
        end else begin
            cnt_now = (m_pos / DIV) % 256;
            tick    = enable && ((m_pos % DIV) == DIV - 1);
            wrap    = enable && ((m_pos % FRAME) == FRAME - 1);
`ifdef AUDIO_PWM_SD_EN
            if (!enable) begin
                m_pwm = 0;
                m_sum = 0;
            end else if (tick) begin
                m_pwm = ((m_sum + m_duty) / 256) != (m_sum / 256);
                m_sum = m_sum + m_duty;
            end
`else
            m_pwm = enable && (cnt_now < m_duty);
`endif
            m_fs = wrap;
            if (sample_valid && m_pend && !wrap) m_ovr = 1;
            else if (clear_ovr) m_ovr = 0;
            if (wrap) begin
                if (sample_valid) m_duty = sample_in;
                else if (m_pend) m_duty = m_hold;
                m_pend = 0;
            end else if (sample_valid) begin
                m_pend = 1;
            end
            if (sample_valid) m_hold = sample_in;
            m_pos = enable ? m_pos + 1 : 0;
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT samples, then
    // compare all outputs just after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        checks++;
        if ({pwm_out, frame_start, duty, overrun} !== {m_pwm, m_fs, m_duty, m_ovr}) begin
            errors++;
            $display("FAIL model t=%0t: got pwm=%b fs=%b duty=%h ovr=%b expected pwm=%b fs=%b duty=%h ovr=%b",
                     $time, pwm_out, frame_start, duty, overrun, m_pwm, m_fs, m_duty, m_ovr);
        end
    endtask

    task automatic idle_inputs();
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        clear_ovr    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_in    = d;
        cycle();
        idle_inputs();
    endtask

    // Run clocks until frame_start is seen; n is the number of clocks taken.
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME + 8);
    endtask

    // Load d, let it repeat once, then measure one full frame of pwm_out.
    task automatic run_window(input logic [7:0] d);
        int   n;
        int   highs;
        int   rises;
        int   first_hi;
        logic prev;
        send(d);
        wait_fs(n);
        check("load_duty", duty, d);
        wait_fs(n);
        check("period", n, FRAME);
        highs = 0; rises = 0; first_hi = -1;
        prev = pwm_out;
        for (int k = 1; k <= FRAME; k++) begin
            cycle();
            if (pwm_out === 1'b1) begin
                highs++;
                if (first_hi < 0) first_hi = k;
                if (prev !== 1'b1) rises++;
            end
            prev = pwm_out;
        end
        check("window_end_fs", frame_start, 1);
        check("high_clocks", highs, d * DIV);
`ifdef AUDIO_PWM_SD_EN
        if (d == 8'h80) check("sd_alternate", rises, 128);
`else
        check("run_count", rises, (d == 0) ? 0 : 1);
        check("first_high", first_hi, (d == 0) ? -1 : 1);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         clr;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int pwm_hi;
        int fs_cnt;

        // Overrun / clear behaviour while the modulator is parked.
        vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h20, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h30, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0};

        // Reset.
        rst = 1'b1; enable = 1'b0; idle_inputs();
        cycle();
        cycle();
        check("rst_pwm", pwm_out, 0);
        check("rst_fs", frame_start, 0);
        check("rst_duty", duty, 8'h80);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            sample_valid = vecs[i].valid;
            sample_in    = vecs[i].data;
            clear_ovr    = vecs[i].clr;
            cycle();
            check("tbl_ovr", overrun, vecs[i].exp_ovr);
            check("tbl_duty", duty, 8'h80);
            check("tbl_pwm", pwm_out, 0);
        end
        idle_inputs();

        // Enable: first frame ends one full period later and loads 0x30.
        enable = 1'b1;
        wait_fs(n);
        check("first_frame", n, FRAME);
        check("first_duty", duty, 8'h30);

        // Frame-window measurements.
        run_window(8'h40);
        run_window(8'h80);
        run_window(8'h00);
        run_window(8'hFF);

        // Two samples in one period: overrun, newest wins.
        send(8'h10);
        cycle();
        send(8'h20);
        check("ovr_two", overrun, 1);
        wait_fs(n);
        check("ovr_duty", duty, 8'h20);
        check("ovr_sticky", overrun, 1);

        // Clear, clear-vs-set, then bypass on the wrap cycle.
        for (int k = 1; k <= FRAME; k++) begin
            idle_inputs();
            if (k == 1 || k == 2) begin
                sample_valid = 1'b1; sample_in = 8'h33; clear_ovr = 1'b1;
            end else if (k == 3) begin
                clear_ovr = 1'b1;
            end else if (k == FRAME) begin
                sample_valid = 1'b1; sample_in = 8'hC0;
            end
            cycle();
            if (k == 1) check("clear_ovr", overrun, 0);
            if (k == 2) check("set_wins", overrun, 1);
            if (k == 3) check("clear_again", overrun, 0);
        end
        idle_inputs();
        check("bypass_fs", frame_start, 1);
        check("bypass_duty", duty, 8'hC0);
        check("bypass_ovr", overrun, 0);
        send(8'h55);
        check("bypass_pend_clr", overrun, 0);
        wait_fs(n);
        check("after_bypass_duty", duty, 8'h55);

        // Disabled for 1000 clocks, then re-enable.
        enable = 1'b0;
        pwm_hi = 0; fs_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (pwm_out !== 1'b0) pwm_hi++;
            if (frame_start !== 1'b0) fs_cnt++;
        end
        check("off_pwm", pwm_hi, 0);
        check("off_fs", fs_cnt, 0);
        enable = 1'b1;
        wait_fs(n);
        check("reenable_frame", n, FRAME);

        // Reset mid-period with duty 0x40 and overrun set.
        send(8'h40);
        wait_fs(n);
        check("pre_rst_duty", duty, 8'h40);
        send(8'h11);
        send(8'h12);
        for (int k = 0; k < 58; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_pwm", pwm_out, 0);
        check("mid_rst_duty", duty, 8'h80);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_fs", frame_start, 0);
        wait_fs(n);
        check("post_rst_frame", n, FRAME);
        check("post_rst_duty", duty, 8'h80);

        // Randomized traffic against the model.
        for (int k = 0; k < 8000; k++) begin
            idle_inputs();
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            if (k < 4000) sample_valid = ($urandom_range(0, FRAME - 1) == 0);
            else sample_valid = ($urandom_range(0, 99) == 0);
            sample_in = 8'($urandom_range(0, 255));
            clear_ovr = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Output stage downstream of the SID filter/volume block. Captures each 8-bit unsigned `sample_out` word on its `sample_valid` strobe into a holding register. Converts the active sample to a 1-bit pulse-width-modulated pin drive, with a 256-tick period and sample updates only at period boundaries. Reports sample overruns and marks frame starts so the upstream sample-rate generator can be checked against the PWM frame rate.

## Interface

Parameters:
- `DIV`, default 1: prescaler; one PWM tick every `DIV` clocks. Legal range 1..256.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `sample_in`  in  8  unsigned sample (0x80 = midscale) from the filter/volume stage
- `sample_valid`  in  1  one-cycle strobe qualifying `sample_in`
- `enable`  in  1  output enable; low parks the modulator
- `clear_ovr`  in  1  clears the sticky `overrun` flag
- `pwm_out`  out  1  registered 1-bit audio drive
- `frame_start`  out  1  one-cycle pulse when a new duty value is loaded
- `duty`  out  8  duty value currently being modulated
- `overrun`  out  1  sticky: a sample was overwritten before being consumed

## Operation

- Reset is synchronous and active-high. Reset values:
  - `pwm_out`=0, `frame_start`=0, `overrun`=0
  - `duty`=0x80, `hold`=0x80, `pend`=0
  - `cnt`=0, `presc`=0, `acc`=0
- Capture path:
  - On `sample_valid`: `hold`<=`sample_in`, `pend`<=1.
- Prescaler:
  - `presc` counts 0..`DIV`-1.
  - `tick` = `enable` & (`presc`==`DIV`-1).
  - With `DIV`=1, every enabled cycle is a tick.
- Period counter:
  - `cnt` is 8 bits and increments on `tick`, wrapping 255→0.
  - `wrap` = `tick` & (`cnt`==255).
- Load on `wrap`:
  - If `sample_valid` is high the same cycle, `duty`<=`sample_in` (bypass) and `pend`<=0.
  - Else if `pend`, `duty`<=`hold` and `pend`<=0.
  - Else `duty` is unchanged; the last sample repeats.
  - `frame_start`<=1 on every `wrap`, including repeats.
- Overrun:
  - Set when `sample_valid` arrives while `pend`=1 and the same cycle is not a `wrap`; the new sample still overwrites `hold`.
  - `clear_ovr` clears it; set wins over a simultaneous clear.
- PWM:
  - `pwm_out`<=`enable` & (`cnt` < `duty`).
  - `duty`=0 gives constant low; `duty`=255 gives 255 of every 256 ticks high.
- `enable` low:
  - `presc`, `cnt` and `acc` held at 0; `pwm_out`<=0; no `wrap` and no `frame_start`.
  - Capture and overrun logic keep running.
  - On re-enable, counting restarts from `cnt`=0 with the current `duty`.
- `DIV` is a static parameter; changing it requires re-elaboration.

## Timing

- `pwm_out` lags `cnt` and `duty` by one clock (registered compare).
- `duty` and `frame_start` update in the clock after the `wrap` cycle. The first high cycle of the new period appears one clock later on `pwm_out`.
- Sample-to-output latency: between 1 and 256×`DIV`+1 clocks, depending on phase relative to `wrap`.
- Nominal upstream rate is one `sample_valid` per 256×`DIV` clocks. A faster rate produces `overrun`; a slower rate produces repeated frames.
- PWM period is exactly 256×`DIV` clocks while enabled.

## Configuration

- `AUDIO_PWM_SD_EN` defined:
  - `pwm_out` becomes first-order delta-sigma.
  - 9-bit accumulator: on each `tick`, `acc`<={1'b0,`acc`[7:0]}+`duty`; `pwm_out`<=`enable` & `acc`[8] of the new sum.
  - Capture, load, `frame_start` and overrun behaviour are unchanged, and `cnt` still defines the frame.
  - Ones density equals `duty`/256 per frame.
- Not defined: plain PWM compare as above; no accumulator is instantiated.

## Test plan

- Reset mid-period with `duty`=0x40 → next cycle `pwm_out`=0, `duty`=0x80, `overrun`=0, `cnt`=0.
- `DIV`=1, enable, `sample_valid` with 0x40 → after next `frame_start`, `pwm_out` is high for exactly 64 of each 256 clocks, as one contiguous run starting 1 clock after `frame_start`.
- Two `sample_valid` (0x10 then 0x20) inside one period → `overrun`=1 and the next `duty`=0x20. `clear_ovr` → 0. `clear_ovr` with a simultaneous overrun → stays 1.
- `sample_valid`=0xC0 on the `wrap` cycle with `pend`=1 holding 0x33 → `duty`=0xC0, `pend`=0, `overrun` stays 0.
- `enable` low for 1000 clocks → `pwm_out`=0 and no `frame_start`. Re-enable → first `frame_start` exactly 256×`DIV` clocks later.
- `AUDIO_PWM_SD_EN`, `DIV`=2, `duty`=0x80 → `pwm_out` toggles high/low on alternate ticks with 128 ones per frame. `duty`=0x00 → constant 0.
